// File: rtl/btn_cmd_pkg.sv
// btn_cmd_pkg: arbiter state type, channel indices and default timing constants for btn_cmd_pulser
package btn_cmd_pkg;
    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;
    localparam int CH_C = 2;
    localparam int CH_S = 1;
    localparam int CH_V = 0;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_HOLDOFF = 2;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: btn (raw async level) -> 2-flop sync -> debounced stable level -> one-cycle rise on stable 0->1
module btn_debounce
    import btn_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, sync, stable, stable_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            sync     <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= btn;
            sync     <= s1;
            stable_q <= stable;
            if (sync == stable)
                cnt <= '0;
            else if (cnt == LAST) begin
                stable <= sync;
                cnt    <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
    assign rise = stable & ~stable_q;
endmodule

// File: rtl/btn_cmd_pulser.sv
// btn_cmd_pulser: btn_c/s/v raw levels -> debounced, priority-arbitrated (C>S>V) one-cycle C/S/V pulses with hold-off; busy/pending/drop report status
module btn_cmd_pulser
    import btn_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_c,
    input  logic       btn_s,
    input  logic       btn_v,
    output logic       C,
    output logic       S,
    output logic       V,
    output logic       busy,
    output logic [2:0] pending,
    output logic       drop
);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF);
    logic [2:0] rise, issue;
    logic [HW-1:0] hcnt;
    arb_state_t state;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_c (.clk(clk), .rst(rst), .btn(btn_c), .rise(rise[CH_C]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_s (.clk(clk), .rst(rst), .btn(btn_s), .rise(rise[CH_S]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_v (.clk(clk), .rst(rst), .btn(btn_v), .rise(rise[CH_V]));
    always_comb
        issue = (state != ARB_IDLE) ? 3'b000 :
                pending[CH_C] ? 3'b1 << CH_C :
                pending[CH_S] ? 3'b1 << CH_S :
                pending[CH_V] ? 3'b1 << CH_V : 3'b000;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            hcnt    <= '0;
            pending <= '0;
            C       <= 1'b0;
            S       <= 1'b0;
            V       <= 1'b0;
            drop    <= 1'b0;
        end else begin
            // a rise in the same edge its bit is issued re-arms the bit
            pending <= (pending & ~issue) | rise;
            drop    <= |(rise & pending & ~issue);
            C       <= issue[CH_C];
            S       <= issue[CH_S];
            V       <= issue[CH_V];
            if (state == ARB_IDLE) begin
                if ((|issue) && HOLDOFF > 0) begin
                    state <= ARB_HOLD;
                    hcnt  <= HOLD_INIT;
                end
            end else begin
                hcnt <= hcnt - 1'b1;
                if (hcnt == HW'(1))
                    state <= ARB_IDLE;
            end
        end
    end
    assign busy = (state == ARB_HOLD) | (|pending);
endmodule

// File: tb/tb_btn_cmd_pulser.sv
// tb_btn_cmd_pulser: table-driven and directed checks of btn_cmd_pulser
module tb_btn_cmd_pulser;
    typedef struct {
        logic       r;
        logic [2:0] b;
        int         n;
        logic [2:0] cmd;
        logic [2:0] pend;
        logic       bz;
        logic       dr;
    } vec_t;
    logic clk = 1'b0;
    logic rst, btn_c, btn_s, btn_v;
    logic C, S, V, busy, drop;
    logic [2:0] pending;
    logic h_C, h_S, h_V, h_busy, h_drop;
    logic [2:0] h_pending;
    int n_vec = 0;
    int n_err = 0;
    vec_t tv[$];
    always #5 clk = ~clk;
    btn_cmd_pulser #(.DEBOUNCE_CYCLES(4), .HOLDOFF(2)) dut (
        .clk(clk), .rst(rst), .btn_c(btn_c), .btn_s(btn_s), .btn_v(btn_v),
        .C(C), .S(S), .V(V), .busy(busy), .pending(pending), .drop(drop)
    );
    btn_cmd_pulser #(.DEBOUNCE_CYCLES(4), .HOLDOFF(12)) dut_h (
        .clk(clk), .rst(rst), .btn_c(btn_c), .btn_s(btn_s), .btn_v(btn_v),
        .C(h_C), .S(h_S), .V(h_V), .busy(h_busy), .pending(h_pending), .drop(h_drop)
    );
    function automatic void add(logic r, logic [2:0] b, int n, logic [2:0] cmd, logic [2:0] pend, logic bz, logic dr);
        vec_t v;
        v.r = r; v.b = b; v.n = n; v.cmd = cmd; v.pend = pend; v.bz = bz; v.dr = dr;
        tv.push_back(v);
    endfunction
    function automatic logic [7:0] obs();
        return {C, S, V, pending, busy, drop};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        n_vec++;
        if ($countones({C, S, V}) > 1 || $countones({h_C, h_S, h_V}) > 1) begin
            n_err++;
            $display("FAIL onehot at %0t: got CSV=%b%b%b hCSV=%b%b%b, expected at most one high", $time, C, S, V, h_C, h_S, h_V);
        end
    end
    initial begin
        int nv, nd, np;
        rst = 1'b1;
        {btn_c, btn_s, btn_v} = 3'b000;
        add(1, 3'b000, 3, 3'b000, 3'b000, 0, 0);
        add(0, 3'b000, 2, 3'b000, 3'b000, 0, 0);
        add(0, 3'b100, 6, 3'b000, 3'b000, 0, 0);
        add(0, 3'b100, 1, 3'b000, 3'b100, 1, 0);
        add(0, 3'b100, 1, 3'b100, 3'b000, 1, 0);
        add(0, 3'b100, 1, 3'b000, 3'b000, 1, 0);
        add(0, 3'b100, 3, 3'b000, 3'b000, 0, 0);
        add(0, 3'b000, 10, 3'b000, 3'b000, 0, 0);
        add(0, 3'b010, 1, 3'b000, 3'b000, 0, 0);
        add(0, 3'b000, 1, 3'b000, 3'b000, 0, 0);
        add(0, 3'b010, 1, 3'b000, 3'b000, 0, 0);
        add(0, 3'b000, 9, 3'b000, 3'b000, 0, 0);
        add(0, 3'b111, 6, 3'b000, 3'b000, 0, 0);
        add(0, 3'b111, 1, 3'b000, 3'b111, 1, 0);
        add(0, 3'b111, 1, 3'b100, 3'b011, 1, 0);
        add(0, 3'b111, 2, 3'b000, 3'b011, 1, 0);
        add(0, 3'b111, 1, 3'b010, 3'b001, 1, 0);
        add(0, 3'b111, 2, 3'b000, 3'b001, 1, 0);
        add(0, 3'b111, 1, 3'b001, 3'b000, 1, 0);
        add(0, 3'b111, 1, 3'b000, 3'b000, 1, 0);
        add(0, 3'b111, 4, 3'b000, 3'b000, 0, 0);
        add(0, 3'b000, 10, 3'b000, 3'b000, 0, 0);
        add(1, 3'b010, 2, 3'b000, 3'b000, 0, 0);
        add(0, 3'b010, 6, 3'b000, 3'b000, 0, 0);
        add(0, 3'b010, 1, 3'b000, 3'b010, 1, 0);
        add(0, 3'b010, 1, 3'b010, 3'b000, 1, 0);
        add(0, 3'b010, 1, 3'b000, 3'b000, 1, 0);
        add(0, 3'b010, 3, 3'b000, 3'b000, 0, 0);
        add(0, 3'b000, 10, 3'b000, 3'b000, 0, 0);
        foreach (tv[i]) begin
            for (int k = 0; k < tv[i].n; k++) begin
                rst = tv[i].r;
                {btn_c, btn_s, btn_v} = tv[i].b;
                step();
                chk($sformatf("vec%0d.%0d", i, k), obs(), {tv[i].cmd, tv[i].pend, tv[i].bz, tv[i].dr});
            end
        end
        rst = 1'b1;
        {btn_c, btn_s, btn_v} = 3'b000;
        step();
        step();
        rst = 1'b0;
        btn_c = 1'b1;
        btn_v = 1'b1;
        nv = 0;
        nd = 0;
        for (int e = 0; e <= 30; e++) begin
            if (e == 4) btn_v = 1'b0;
            if (e == 8) btn_v = 1'b1;
            step();
            nv += int'(h_V);
            nd += int'(h_drop);
            if (e == 13) chk("ovr_pend", 8'(h_pending), 8'b001);
            if (e == 14) chk("ovr_drop", 8'(h_drop), 8'd1);
            if (e == 15) chk("ovr_drop_end", 8'(h_drop), 8'd0);
            if (e == 20) chk("ovr_v_issue", 8'({h_V, h_pending}), 8'b1000);
        end
        chk("ovr_v_count", 8'(nv), 8'd1);
        chk("ovr_drop_count", 8'(nd), 8'd1);
        rst = 1'b1;
        {btn_c, btn_s, btn_v} = 3'b000;
        step();
        step();
        rst = 1'b0;
        {btn_c, btn_s, btn_v} = 3'b111;
        repeat (8) step();
        chk("mid_before", obs(), {3'b100, 3'b011, 1'b1, 1'b0});
        rst = 1'b1;
        {btn_c, btn_s, btn_v} = 3'b000;
        step();
        chk("mid_reset", obs(), 8'b0);
        rst = 1'b0;
        nv = 0;
        np = 0;
        repeat (20) begin
            step();
            nv += $countones({C, S, V});
            np += int'(|pending);
        end
        chk("mid_no_late_pulse", 8'(nv), 8'd0);
        chk("mid_no_pending", 8'(np), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
